parity_frame_rx: RTL

Serial parity-checked frame receiver. The block consumes a bit-serial stream of DATA_W data bits (LSB first) followed by one parity bit, as produced by the team's XOR parity generator. It deserializes the data, recomputes parity with a running XOR, and presents each completed word on a valid/ready output port with a parity-error flag. It sits between a serial link front end and word-wide consumer logic.

---
 rtl/parity_frame_rx_pkg.sv | 21 ++
 rtl/parity_frame_rx_if.sv | 24 ++
 rtl/parity_frame_rx_accum.sv | 29 ++
 rtl/parity_frame_rx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/parity_frame_rx_pkg.sv
// Shared parity definitions: receiver FSM states, parity-mode constants and
// a vector parity helper used by both the generator and the receiver.
package parity_pkg;

    localparam int unsigned MAX_DATA_W = 32;

    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY
    } state_t;

    // Parity bit a generator appends so that data ^ parity matches the mode.
    function automatic logic vec_parity(input logic [MAX_DATA_W-1:0] v, input bit odd);
        return (^v) ^ odd;
    endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// Serial-in / word-out port bundle of the parity frame receiver.
interface parity_frame_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_bit;
    logic              in_sof;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_par_err;
    logic              overrun;
    logic              frame_err;

    modport master (
        output in_valid, in_bit, in_sof, out_ready,
        input  out_valid, out_data, out_par_err, overrun, frame_err
    );

    modport slave (
        input  in_valid, in_bit, in_sof, out_ready,
        output out_valid, out_data, out_par_err, overrun, frame_err
    );
endinterface

// File: rtl/parity_frame_rx_accum.sv
// One-bit running XOR register; a seed load restarts it with the first bit
// already folded in, an enable folds in one more bit.
module parity_accum #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_seed_en,
    input  logic i_seed,
    input  logic i_en,
    input  logic i_bit,
    output logic o_acc
);

    logic r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= RESET_VAL;
        end else if (i_seed_en) begin
            r_acc <= i_seed ^ i_bit;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_bit;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/parity_frame_rx.sv
// Parity-checked serial frame receiver: deserializes DATA_W bits LSB first,
// checks the trailing parity bit, and presents words on a valid/ready port.
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          ODD_PARITY = PARITY_EVEN
) (
    input logic            clk,
    input logic            rst_n,
    parity_frame_rx_if.slave bus
);

    localparam int unsigned       CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(DATA_W - 1);

    state_t             r_state,     w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
    logic [DATA_W-1:0]  r_shift,     w_shift_nxt;
    logic [DATA_W-1:0]  r_out_data,  w_out_data_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic               r_par_err,   w_par_err_nxt;
    logic               r_overrun,   w_overrun_nxt;
    logic               r_frame_err, w_frame_err_nxt;

    logic w_sof;
    logic w_beat;
    logic w_acc;
    logic w_acc_seed_en;
    logic w_acc_en;

    assign w_sof  = bus.in_valid & bus.in_sof;
    assign w_beat = bus.in_valid & ~bus.in_sof;

    parity_accum #(
        .RESET_VAL (ODD_PARITY)
    ) u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_seed_en (w_acc_seed_en),
        .i_seed    (ODD_PARITY),
        .i_en      (w_acc_en),
        .i_bit     (bus.in_bit),
        .o_acc     (w_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_par_err   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_par_err   <= w_par_err_nxt;
            r_overrun   <= w_overrun_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_par_err_nxt   = r_par_err;
        w_overrun_nxt   = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_acc_seed_en   = 1'b0;
        w_acc_en        = 1'b0;

        // Output slot drains independently of the shift path.
        if (r_out_valid && bus.out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        if (w_sof) begin
            // A start-of-frame always restarts; mid-frame it aborts the partial word.
            w_frame_err_nxt = (r_state != ST_IDLE);
            w_shift_nxt     = '0;
            w_shift_nxt[0]  = bus.in_bit;
            w_cnt_nxt       = CNT_W'(1);
            w_acc_seed_en   = 1'b1;
            w_state_nxt     = (DATA_W == 1) ? ST_PARITY : ST_DATA;
        end else if (w_beat) begin
            case (r_state)
                ST_DATA: begin
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            w_shift_nxt[i] = bus.in_bit;
                        end
                    end
                    w_acc_en = 1'b1;
                    if (r_cnt != CNT_MAX) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    if (r_cnt == LAST_DATA) begin
                        w_state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (!r_out_valid || bus.out_ready) begin
                        w_out_data_nxt  = r_shift;
                        w_par_err_nxt   = w_acc ^ bus.in_bit;
                        w_out_valid_nxt = 1'b1;
                    end else begin
                        w_overrun_nxt = 1'b1;
                    end
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_par_err = r_par_err;
    assign bus.overrun     = r_overrun;
    assign bus.frame_err   = r_frame_err;

endmodule
